// File: rtl/reshuffle.sv
// reshuffle: reads an IMG_DIM x IMG_DIM 8-bit image out of SRAM group A
// (4 banks, pixel-unshuffled layout) and re-serialises it as a raster-order
// pixel stream, one pixel per beat.
// Optional feature macro: RESHUFFLE_COORD_EN adds out_row/out_col outputs.
// Handshake: a pixel transfers on a rising clk edge where out_valid && out_ready
// are both high; once out_valid is raised, out_valid, out_data and out_last hold
// steady until that transfer happens.
module reshuffle #(
   parameter int CH_NUM       = 4,
   parameter int ACT_PER_ADDR = 4,
   parameter int BW_PER_ACT   = 8,
   parameter int IMG_DIM      = 28
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   output logic                                       busy,
   output logic                                       done,
   output logic [3:0]                                 sram_ren_n,
   output logic [5:0]                                 sram_raddr_a,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a0,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a1,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a2,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a3,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [BW_PER_ACT-1:0]                      out_data,
   output logic                                       out_last,
`ifdef RESHUFFLE_COORD_EN
   output logic [4:0]                                 out_row,
   output logic [4:0]                                 out_col,
`endif
   output logic [1:0]                                 dbg_state
);

   localparam int G_NUM = IMG_DIM / 4;
   localparam int DW    = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
   localparam int GW    = 4 * BW_PER_ACT;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state, next_state;
   logic            done_set;

   logic [4:0]      issue_row;
   logic [2:0]      issue_g;
   logic            issue_en, issue_last_grp;
   logic [2:0]      occ;

   // read pipeline: stage 1 = read on the bus, stage 2 = data returned by SRAM
   logic            v1, v2;
   logic [3:0]      tag1, tag2;          // {r[1:0], g[0], r[2]}
   logic            last1, last2;

   logic [GW-1:0]   fifo_data [2];
   logic            fifo_last [2];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      fifo_cnt;
   logic [1:0]      pix_p;
   logic            push, pop, fire, last_fire;

   logic [DW-1:0]   sel_word;
   logic [GW-1:0]   push_data;
   logic [3:0]      lane;
   logic [1:0]      pp;

   assign dbg_state      = state;
   assign busy           = (state != S_IDLE) | done;
   assign occ            = 3'(fifo_cnt) + 3'(v1) + 3'(v2);
   assign issue_en       = (state == S_RUN) && (occ < 3'd2);
   assign issue_last_grp = (issue_row == 5'(IMG_DIM - 1)) && (issue_g == 3'(G_NUM - 1));
   assign push           = v2;
   assign out_valid      = (fifo_cnt != 2'd0);
   assign fire           = out_valid && out_ready;
   assign pop            = fire && (pix_p == 2'd3);
   assign last_fire      = pop && fifo_last[rd_ptr];
   assign out_data       = fifo_data[rd_ptr][pix_p*BW_PER_ACT +: BW_PER_ACT];
   assign out_last       = out_valid && fifo_last[rd_ptr] && (pix_p == 2'd3);

   // State register and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         done  <= done_set;
      end
   end

   // Next-state: start only honoured in IDLE; DRAIN waits for the final pixel
   always_comb begin
      next_state = state;
      done_set   = 1'b0;
      case (state)
         S_IDLE:  if (start) next_state = S_RUN;
         S_RUN:   if (issue_en && issue_last_grp) next_state = S_DRAIN;
         S_DRAIN: if (last_fire) begin
            next_state = S_IDLE;
            done_set   = 1'b1;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Issue side: one group read per cycle while fewer than 2 groups are held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_row    <= '0;
         issue_g      <= '0;
         sram_ren_n   <= 4'hf;
         sram_raddr_a <= '0;
         v1           <= 1'b0;
         tag1         <= '0;
         last1        <= 1'b0;
      end else begin
         sram_ren_n <= 4'hf;
         v1         <= issue_en;
         if (issue_en) begin
            sram_ren_n   <= ~(4'b0001 << {issue_row[2], issue_g[0]});
            sram_raddr_a <= 6'(issue_row[4:3]) * 6'd6 + 6'(issue_g[2:1]);
            tag1         <= {issue_row[1:0], issue_g[0], issue_row[2]};
            last1        <= issue_last_grp;
            if (issue_g == 3'(G_NUM - 1)) begin
               issue_g   <= '0;
               issue_row <= issue_last_grp ? 5'd0 : issue_row + 5'd1;
            end else begin
               issue_g <= issue_g + 3'd1;
            end
         end
      end
   end

   // Tag follows the read into the cycle where SRAM data is on the bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2    <= 1'b0;
         tag2  <= '0;
         last2 <= 1'b0;
      end else begin
         v2    <= v1;
         tag2  <= tag1;
         last2 <= last1;
      end
   end

   // Pick the tagged bank and gather the group's 4 pixels out of their byte lanes
   always_comb begin
      sel_word  = sram_rdata_a0;
      push_data = '0;
      lane      = '0;
      pp        = '0;
      case ({tag2[0], tag2[1]})
         2'd0:    sel_word = sram_rdata_a0;
         2'd1:    sel_word = sram_rdata_a1;
         2'd2:    sel_word = sram_rdata_a2;
         default: sel_word = sram_rdata_a3;
      endcase
      for (int p = 0; p < 4; p++) begin
         pp   = 2'(p);
         // 15 - 8*r[0] - 4*p[0] - 2*r[1] - p[1] is the complement of these bits
         lane = ~{tag2[2], pp[0], tag2[3], pp[1]};
         push_data[p*BW_PER_ACT +: BW_PER_ACT] = sel_word[lane*BW_PER_ACT +: BW_PER_ACT];
      end
   end

   // Two-entry group FIFO; push and pop in the same cycle keep occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_last[wr_ptr] <= last2;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Pixel index within the head group advances on each transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pix_p <= '0;
      else if (fire) pix_p <= pix_p + 2'd1;
   end

`ifdef RESHUFFLE_COORD_EN
   // Coordinates of the pixel currently presented on out_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_row <= '0;
         out_col <= '0;
      end else if (fire) begin
         if (out_col == 5'(IMG_DIM - 1)) begin
            out_col <= '0;
            out_row <= (out_row == 5'(IMG_DIM - 1)) ? 5'd0 : out_row + 5'd1;
         end else begin
            out_col <= out_col + 5'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reshuffle.sv
// Bench for reshuffle: SRAM bank model loaded through an independent layout
// model, expected pixels and expected reads queued at each run start and popped
// as the DUT reads / emits pixels.
module tb_reshuffle;

   logic         clk;
   logic         rst;
   logic         start;
   logic         busy;
   logic         done;
   logic [3:0]   sram_ren_n;
   logic [5:0]   sram_raddr_a;
   logic [127:0] rdata [4];
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic [1:0]   dbg_state;
`ifdef RESHUFFLE_COORD_EN
   logic [4:0]   out_row;
   logic [4:0]   out_col;
`endif

   reshuffle dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .sram_ren_n    (sram_ren_n),
      .sram_raddr_a  (sram_raddr_a),
      .sram_rdata_a0 (rdata[0]),
      .sram_rdata_a1 (rdata[1]),
      .sram_rdata_a2 (rdata[2]),
      .sram_rdata_a3 (rdata[3]),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
`ifdef RESHUFFLE_COORD_EN
      .out_row       (out_row),
      .out_col       (out_col),
`endif
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [127:0] mem [4][64];
   logic [7:0]   img [28][28];
   logic [7:0]   exp_q[$];
   logic [7:0]   rd_q[$];

   int   checks = 0;
   int   errors = 0;
   int   beat_cnt, read_cnt, done_cnt, mon_cyc, first_fire, last_fire_cyc;
   bit   mon_en, last_seen, prev_hold, aborted;
   logic [7:0] prev_data;
   logic       prev_last;
   logic [7:0] beat153_val;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // layout model
   function automatic logic [1:0] lay_bank(input int r, input int g);
      return 2'(((r >> 2) & 1) * 2 + (g & 1));
   endfunction

   function automatic logic [5:0] lay_addr(input int r, input int g);
      return 6'(6 * ((r >> 3) & 3) + ((g >> 1) & 3));
   endfunction

   function automatic int lay_lane(input int r, input int c);
      int p;
      p = c % 4;
      return 15 - 8 * (r & 1) - 2 * ((r >> 1) & 1) - 4 * (p & 1) - ((p >> 1) & 1);
   endfunction

   // SRAM model: data returned one cycle after the read
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (!sram_ren_n[b]) rdata[b] <= mem[b][sram_raddr_a];
   end

   task automatic load_image(input bit single);
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 64; a++) mem[b][a] = '0;
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++) begin
            if (single) img[r][c] = (r == 5 && c == 13) ? 8'ha5 : 8'h00;
            else        img[r][c] = 8'((r * 28 + c) % 256);
            mem[lay_bank(r, c / 4)][lay_addr(r, c / 4)][8 * lay_lane(r, c) +: 8] = img[r][c];
         end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         mon_cyc++;
         if (last_seen) begin
            check_eq("done_after_last", done, 1);
            last_seen = 0;
         end
         if (done) begin
            done_cnt++;
            check_eq("busy_with_done", busy, 1);
         end
         if (prev_hold) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, prev_data);
            check_eq("hold_last", out_last, prev_last);
         end
         if (sram_ren_n != 4'hf) begin
            logic [1:0] bank;
            logic [7:0] exp_rd;
            bank = 2'd0;
            for (int b = 0; b < 4; b++) if (!sram_ren_n[b]) bank = 2'(b);
            check_eq("ren_onehot", 32'($countones(~sram_ren_n)), 1);
            read_cnt++;
            if (rd_q.size() == 0) check_eq("extra_read", read_cnt, 196);
            else begin
               exp_rd = rd_q.pop_front();
               check_eq("read_bank_addr", {bank, sram_raddr_a}, exp_rd);
            end
         end
         if (out_valid && out_ready) begin
            logic [7:0] exp_px;
            if (exp_q.size() == 0) check_eq("extra_pixel", beat_cnt, 784);
            else begin
               exp_px = exp_q.pop_front();
               check_eq("pixel", out_data, exp_px);
            end
            check_eq("last_flag", out_last, (beat_cnt == 783) ? 1 : 0);
`ifdef RESHUFFLE_COORD_EN
            check_eq("coord_row", out_row, beat_cnt / 28);
            check_eq("coord_col", out_col, beat_cnt % 28);
`endif
            if (beat_cnt == 0) first_fire = mon_cyc;
            if (beat_cnt == 153) beat153_val = out_data;
            if (out_last) begin
               last_fire_cyc = mon_cyc;
               last_seen = 1;
            end
            beat_cnt++;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
      end
   end

   // driver: one readback; mode 0 ready high, 1 random, 2 low for 20 cycles
   task automatic run_image(input int mode, input bit start_again, input int abort_at);
      int k;
      for (int r = 0; r < 28; r++)
         for (int g = 0; g < 7; g++) rd_q.push_back({lay_bank(r, g), lay_addr(r, g)});
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++) exp_q.push_back(img[r][c]);
      beat_cnt = 0; read_cnt = 0; done_cnt = 0;
      last_seen = 0; prev_hold = 0; aborted = 0;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      check_eq("busy_after_start", busy, 1);
      while (done_cnt == 0 && k < 5000 && !aborted) begin
         @(posedge clk);
         k++;
         #1;
         if (k == 1) begin
            check_eq("first_ren", sram_ren_n, 4'b1110);
            check_eq("first_addr", sram_raddr_a, 0);
         end
         if (k == 2) check_eq("valid_edge2", out_valid, 0);
         if (k == 3) check_eq("valid_edge3", out_valid, 1);
         if (mode == 2 && k == 20) check_eq("stall_reads", read_cnt, 2);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (k >= 20);
         endcase
         start = start_again && (k == 10);
         if (abort_at >= 0 && beat_cnt >= abort_at) begin
            rst = 1'b1;
            mon_en = 1'b0;
            start = 1'b0;
            #1;
            check_eq("abort_busy", busy, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_ren", sram_ren_n, 4'hf);
            check_eq("abort_addr", sram_raddr_a, 0);
            check_eq("abort_valid", out_valid, 0);
            check_eq("abort_data", out_data, 0);
            check_eq("abort_last", out_last, 0);
            aborted = 1;
         end
      end
      if (!aborted) begin
         if (k >= 5000) check_eq("timeout", k, 0);
         repeat (3) @(posedge clk);
         #1;
         check_eq("end_busy", busy, 0);
         check_eq("done_count", done_cnt, 1);
         check_eq("beat_count", beat_cnt, 784);
         check_eq("read_count", read_cnt, 196);
         check_eq("exp_q_left", exp_q.size(), 0);
         check_eq("rd_q_left", rd_q.size(), 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; mon_en = 1'b0;
      beat153_val = '0;
      for (int b = 0; b < 4; b++) rdata[b] = '0;
      load_image(0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ren", sram_ren_n, 4'hf);
      check_eq("rst_addr", sram_raddr_a, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_last", out_last, 0);
      check_eq("rst_state", dbg_state, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // full-rate ramp image, no bubbles after the first pixel
      run_image(0, 0, -1);
      check_eq("no_bubble", last_fire_cyc - first_fire, 783);

      // random backpressure
      run_image(1, 0, -1);

      // sink stalled for 20 cycles
      run_image(2, 0, -1);

      // single marked pixel
      load_image(1);
      run_image(0, 0, -1);
      check_eq("pixel_5_13", beat153_val, 8'ha5);

      // start during RUN is ignored
      load_image(0);
      run_image(0, 1, -1);

      // reset mid-run then a fresh run
      run_image(0, 0, 300);
      exp_q.delete();
      rd_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      run_image(1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
